// File: rtl/axi_mem_sub.sv
// Single-beat AXI4 memory subordinate: 64-bit words, one write and one read outstanding.
// Define AXI_MEM_SUB_DECERR_EN to return DECERR for addresses beyond DEPTH words.
package axi_mem_sub_pkg;
    parameter int unsigned AXI_ADDR_WIDTH = 32;
    parameter int unsigned AXI_ID_WIDTH   = 4;
    parameter int unsigned AXI_DATA_WIDTH = 64;
    parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AXI_STRB_WIDTH-1:0] strb;
        logic                      last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [1:0]              resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } axi_r_t;
endpackage

module axi_mem_sub
    import axi_mem_sub_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic    clk,
    input  logic    rst,
    input  axi_aw_t i_axi_s_aw,
    input  logic    i_axi_s_awvalid,
    output logic    o_axi_s_awready,
    input  axi_w_t  i_axi_s_w,
    input  logic    i_axi_s_wvalid,
    output logic    o_axi_s_wready,
    output axi_b_t  o_axi_s_b,
    output logic    o_axi_s_bvalid,
    input  logic    i_axi_s_bready,
    input  axi_ar_t i_axi_s_ar,
    input  logic    i_axi_s_arvalid,
    output logic    o_axi_s_arready,
    output axi_r_t  o_axi_s_r,
    output logic    o_axi_s_rvalid,
    input  logic    i_axi_s_rready
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    logic                      ready_en;
    logic                      aw_full;
    logic [AXI_ID_WIDTH-1:0]   aw_id_q;
    logic [IDX_W-1:0]          aw_idx_q;
    logic                      aw_oor_q;
    logic                      w_full;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [AXI_STRB_WIDTH-1:0] w_strb_q;
    logic                      bvalid_q;
    axi_b_t                    b_q;
    logic                      rvalid_q;
    axi_r_t                    r_q;

    logic             awready, wready, arready;
    logic             aw_hs, w_hs, ar_hs, commit;
    logic             aw_oor, ar_oor;
    logic [IDX_W-1:0] ar_idx;
    logic             unused_bits;

`ifdef AXI_MEM_SUB_DECERR_EN
    assign aw_oor = |i_axi_s_aw.addr[AXI_ADDR_WIDTH-1:3+IDX_W];
    assign ar_oor = |i_axi_s_ar.addr[AXI_ADDR_WIDTH-1:3+IDX_W];
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    assign unused_bits = ^{i_axi_s_aw.len, i_axi_s_aw.size, i_axi_s_aw.burst, i_axi_s_aw.addr[2:0],
                           i_axi_s_aw.addr[AXI_ADDR_WIDTH-1:3+IDX_W],
                           i_axi_s_ar.len, i_axi_s_ar.size, i_axi_s_ar.burst, i_axi_s_ar.addr[2:0],
                           i_axi_s_ar.addr[AXI_ADDR_WIDTH-1:3+IDX_W],
                           i_axi_s_w.id, i_axi_s_w.last};

    // ready_en keeps every ready low until the first edge after reset is released
    assign awready = ready_en && !aw_full;
    assign wready  = ready_en && !w_full;
    assign arready = ready_en && !rvalid_q;

    assign aw_hs  = i_axi_s_awvalid && awready;
    assign w_hs   = i_axi_s_wvalid && wready;
    assign ar_hs  = i_axi_s_arvalid && arready;
    assign commit = aw_full && w_full && !bvalid_q;
    assign ar_idx = i_axi_s_ar.addr[3 +: IDX_W];

    assign o_axi_s_awready = awready;
    assign o_axi_s_wready  = wready;
    assign o_axi_s_arready = arready;
    assign o_axi_s_bvalid  = bvalid_q;
    assign o_axi_s_b       = b_q;
    assign o_axi_s_rvalid  = rvalid_q;
    assign o_axi_s_r       = r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            aw_full  <= 1'b0;
            aw_id_q  <= '0;
            aw_idx_q <= '0;
            aw_oor_q <= 1'b0;
            w_full   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            b_q      <= '0;
        end else begin
            ready_en <= 1'b1;
            if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_id_q  <= i_axi_s_aw.id;
                aw_idx_q <= i_axi_s_aw.addr[3 +: IDX_W];
                aw_oor_q <= aw_oor;
            end else if (commit) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= i_axi_s_w.data;
                w_strb_q <= i_axi_s_w.strb;
            end else if (commit) begin
                w_full <= 1'b0;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                b_q.id   <= aw_id_q;
                b_q.resp <= aw_oor_q ? RESP_DECERR : RESP_OKAY;
            end else if (bvalid_q && i_axi_s_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Memory is deliberately left out of reset so contents survive it
    always_ff @(posedge clk) begin
        if (commit && !rst && !aw_oor_q) begin
            for (int unsigned i = 0; i < AXI_STRB_WIDTH; i++) begin
                if (w_strb_q[i]) mem[aw_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            r_q      <= '0;
        end else if (ar_hs) begin
            rvalid_q  <= 1'b1;
            r_q.id    <= i_axi_s_ar.id;
            r_q.data  <= ar_oor ? '0 : mem[ar_idx];
            r_q.resp  <= ar_oor ? RESP_DECERR : RESP_OKAY;
            r_q.last  <= 1'b1;
        end else if (rvalid_q && i_axi_s_rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_mem_sub.sv
// Directed and randomized self-checking bench for axi_mem_sub against a word-level memory model.
module tb_axi_mem_sub;
    import axi_mem_sub_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    axi_aw_t aw;
    logic    awvalid, awready;
    axi_w_t  w;
    logic    wvalid, wready;
    axi_b_t  b;
    logic    bvalid, bready;
    axi_ar_t ar;
    logic    arvalid, arready;
    axi_r_t  r;
    logic    rvalid, rready;

    int nchecks = 0;
    int nerrs   = 0;

    logic [63:0] model [logic [11:0]];

    always #5 clk = ~clk;

    axi_mem_sub #(.DEPTH(4096)) dut (
        .clk(clk), .rst(rst),
        .i_axi_s_aw(aw), .i_axi_s_awvalid(awvalid), .o_axi_s_awready(awready),
        .i_axi_s_w(w), .i_axi_s_wvalid(wvalid), .o_axi_s_wready(wready),
        .o_axi_s_b(b), .o_axi_s_bvalid(bvalid), .i_axi_s_bready(bready),
        .i_axi_s_ar(ar), .i_axi_s_arvalid(arvalid), .o_axi_s_arready(arready),
        .o_axi_s_r(r), .o_axi_s_rvalid(rvalid), .i_axi_s_rready(rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [7:0] strb);
        logic [63:0] res;
        res = old;
        for (int i = 0; i < 8; i++) if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
        return res;
    endfunction

    function automatic bit out_of_range(input logic [31:0] addr);
`ifdef AXI_MEM_SUB_DECERR_EN
        return addr[31:15] != 17'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] model_rd(input logic [31:0] addr);
        if (out_of_range(addr)) return 64'd0;
        if (!model.exists(addr[14:3])) return 64'hx;
        return model[addr[14:3]];
    endfunction

    task automatic model_wr(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
        if (!out_of_range(addr))
            model[addr[14:3]] = merge(model.exists(addr[14:3]) ? model[addr[14:3]] : 64'hx, data, strb);
    endtask

    task automatic set_aw(input logic [31:0] addr, input logic [3:0] id);
        aw = '0; aw.addr = addr; aw.id = id; aw.size = 3'd3; aw.burst = 2'd1;
    endtask

    task automatic set_w(input logic [63:0] data, input logic [7:0] strb);
        w = '0; w.data = data; w.strb = strb; w.last = 1'b1;
    endtask

    // Called at a negedge with valids raised; returns at the negedge after the handshake edge
    task automatic wait_hs(input string tag, input bit need_aw, input bit need_w, input bit need_ar);
        int n;
        n = 0;
        while (((need_aw && !awready) || (need_w && !wready) || (need_ar && !arready)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_hs_in_time"}, 64'(n < 20), 64'd1);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] id, input logic [63:0] data,
                      input logic [7:0] strb, input int gap, input bit w_first, input string tag);
        logic [1:0] eresp;
        eresp = out_of_range(addr) ? 2'd3 : 2'd0;
        set_aw(addr, id);
        set_w(data, strb);
        if (gap == 0) begin
            awvalid = 1'b1; wvalid = 1'b1;
            wait_hs(tag, 1'b1, 1'b1, 1'b0);
            awvalid = 1'b0; wvalid = 1'b0;
        end else if (w_first) begin
            wvalid = 1'b1;
            wait_hs(tag, 1'b0, 1'b1, 1'b0);
            wvalid = 1'b0;
            repeat (gap) begin
                chk({tag, "_wready_held"}, 64'(wready), 64'd0);
                @(negedge clk);
            end
            awvalid = 1'b1;
            wait_hs(tag, 1'b1, 1'b0, 1'b0);
            awvalid = 1'b0;
            chk({tag, "_wready_until_commit"}, 64'(wready), 64'd0);
        end else begin
            awvalid = 1'b1;
            wait_hs(tag, 1'b1, 1'b0, 1'b0);
            awvalid = 1'b0;
            repeat (gap) begin
                chk({tag, "_awready_held"}, 64'(awready), 64'd0);
                @(negedge clk);
            end
            wvalid = 1'b1;
            wait_hs(tag, 1'b0, 1'b1, 1'b0);
            wvalid = 1'b0;
        end
        chk({tag, "_b_not_yet"}, 64'(bvalid), 64'd0);
        @(negedge clk);
        chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
        chk({tag, "_bid"}, 64'(b.id), 64'(id));
        chk({tag, "_bresp"}, 64'(b.resp), 64'(eresp));
        model_wr(addr, data, strb);
        @(negedge clk);
        chk({tag, "_bvalid_clr"}, 64'(bvalid), 64'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [3:0] id, input string tag);
        logic [63:0] edata;
        logic [1:0]  eresp;
        edata = model_rd(addr);
        eresp = out_of_range(addr) ? 2'd3 : 2'd0;
        ar = '0; ar.addr = addr; ar.id = id; ar.size = 3'd3; ar.burst = 2'd1;
        arvalid = 1'b1;
        wait_hs(tag, 1'b0, 1'b0, 1'b1);
        arvalid = 1'b0;
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, "_rdata"}, r.data, edata);
        chk({tag, "_rid_resp_last"}, 64'({r.id, r.resp, r.last}), 64'({id, eresp, 1'b1}));
        @(negedge clk);
        chk({tag, "_rvalid_clr"}, 64'(rvalid), 64'd0);
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_awready"}, 64'(awready), 64'd0);
        chk({tag, "_wready"}, 64'(wready), 64'd0);
        chk({tag, "_arready"}, 64'(arready), 64'd0);
        chk({tag, "_bvalid"}, 64'(bvalid), 64'd0);
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, "_b_zero"}, 64'(b), 64'd0);
        chk({tag, "_r_zero"}, r.data | 64'({r.id, r.resp, r.last}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        logic [63:0] d;
        rst = 1'b1;
        aw = '0; w = '0; ar = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        // Reset behaviour
        repeat (3) @(negedge clk);
        chk_all_idle("reset");
        rst = 1'b0;
        chk("awready_before_first_edge", 64'(awready), 64'd0);
        @(negedge clk);
        chk("awready_after_reset", 64'(awready), 64'd1);
        chk("wready_after_reset", 64'(wready), 64'd1);
        chk("arready_after_reset", 64'(arready), 64'd1);

        // Basic write/read, then W ahead of AW with partial strobe
        wr(32'h40, 4'd1, 64'h1122334455667788, 8'hFF, 0, 1'b0, "t_basic_wr");
        rd(32'h40, 4'd1, "t_basic_rd");
        wr(32'h40, 4'd2, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 5, 1'b1, "t_w_first");
        rd(32'h40, 4'd2, "t_w_first_rd");
        chk("t_w_first_value", r.data, 64'h11223344AAAAAAAA);

        // B back-pressure with a second write queued behind it
        bready = 1'b0;
        set_aw(32'h80, 4'd2); set_w(64'hCAFEF00D12345678, 8'hFF);
        awvalid = 1'b1; wvalid = 1'b1;
        wait_hs("t_bp_first", 1'b1, 1'b1, 1'b0);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("t_bp_bvalid", 64'(bvalid), 64'd1);
        model_wr(32'h80, 64'hCAFEF00D12345678, 8'hFF);
        set_aw(32'h88, 4'd3); set_w(64'h0BADBEEF55AA55AA, 8'hFF);
        awvalid = 1'b1; wvalid = 1'b1;
        wait_hs("t_bp_second", 1'b1, 1'b1, 1'b0);
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) begin
            chk("t_bp_slots_full", 64'({awready, wready}), 64'd0);
            chk("t_bp_b_stable", 64'({bvalid, b.id, b.resp}), 64'({1'b1, 4'd2, 2'd0}));
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        chk("t_bp_accepted", 64'(bvalid), 64'd0);
        @(negedge clk);
        chk("t_bp_second_b", 64'({bvalid, b.id, b.resp}), 64'({1'b1, 4'd3, 2'd0}));
        model_wr(32'h88, 64'h0BADBEEF55AA55AA, 8'hFF);
        @(negedge clk);
        rd(32'h80, 4'd4, "t_bp_rd80");
        rd(32'h88, 4'd4, "t_bp_rd88");

        // R back-pressure
        rready = 1'b0;
        ar = '0; ar.addr = 32'h40; ar.id = 4'd5;
        arvalid = 1'b1;
        wait_hs("t_rbp", 1'b0, 1'b0, 1'b1);
        arvalid = 1'b0;
        repeat (3) begin
            chk("t_rbp_arready", 64'(arready), 64'd0);
            chk("t_rbp_rvalid_id", 64'({rvalid, r.id}), 64'({1'b1, 4'd5}));
            chk("t_rbp_data", r.data, model_rd(32'h40));
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        chk("t_rbp_done", 64'({rvalid, arready}), 64'({1'b0, 1'b1}));

        // Reset with AW captured and W pending
        set_aw(32'h40, 4'd6);
        awvalid = 1'b1;
        wait_hs("t_rst_aw", 1'b1, 1'b0, 1'b0);
        awvalid = 1'b0;
        chk("t_rst_aw_held", 64'(awready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk_all_idle("t_rst_mid");
        rst = 1'b0;
        @(negedge clk);
        chk("t_rst_ready_back", 64'({awready, wready, arready}), 64'h7);
        set_w(64'hDEADDEADDEADDEAD, 8'hFF);
        wvalid = 1'b1;
        wait_hs("t_rst_w", 1'b0, 1'b1, 1'b0);
        wvalid = 1'b0;
        repeat (3) begin
            chk("t_rst_no_commit", 64'(bvalid), 64'd0);
            @(negedge clk);
        end
        rd(32'h40, 4'd6, "t_rst_rd");
        set_aw(32'h48, 4'd7);
        awvalid = 1'b1;
        wait_hs("t_rst_aw2", 1'b1, 1'b0, 1'b0);
        awvalid = 1'b0;
        @(negedge clk);
        chk("t_rst_aw2_b", 64'({bvalid, b.id}), 64'({1'b1, 4'd7}));
        model_wr(32'h48, 64'hDEADDEADDEADDEAD, 8'hFF);
        @(negedge clk);
        rd(32'h48, 4'd7, "t_rst_rd48");

        // Upper address bits: aliasing or DECERR depending on build
        wr(32'h0, 4'd8, 64'h0123456789ABCDEF, 8'hFF, 0, 1'b0, "t_hi_wr0");
        wr(32'h10000, 4'd9, 64'hFEDCBA9876543210, 8'hFF, 0, 1'b0, "t_hi_wr");
        rd(32'h10000, 4'd10, "t_hi_rd");
        rd(32'h0, 4'd11, "t_hi_rd0");

        // Randomized traffic over a small set of initialised words
        for (int k = 0; k < 8; k++)
            wr(32'h1000 + 32'(k * 8), 4'(k), {$urandom, $urandom}, 8'hFF, 0, 1'b0, "r_init");
        for (int i = 0; i < 60; i++) begin
            addr = 32'h1000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) addr[20:15] = 6'($urandom_range(1, 63));
            if ($urandom_range(0, 1) == 0) begin
                d = {$urandom, $urandom};
                wr(addr, 4'($urandom), d, 8'($urandom), $urandom_range(0, 3), 1'($urandom), "r_wr");
            end else begin
                rd(addr, 4'($urandom), "r_rd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule

// File: doc/axi_mem_sub.md
AXI_MEM_SUB -- requirements
Module: axi_mem_sub

Interface
REQ-001 SHALL have parameter DEPTH, default 4096: number of 64-bit memory words; power of two; IDX_W = log2(DEPTH).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port i_axi_s_aw, input, axi_aw_t: write address (id, addr, len, size, burst, ...).
REQ-005 SHALL have ports i_axi_s_awvalid (input, 1) and o_axi_s_awready (output, 1): the AW handshake.
REQ-006 SHALL have port i_axi_s_w, input, axi_w_t: write data (id, data, strb, last).
REQ-007 SHALL have ports i_axi_s_wvalid (input, 1) and o_axi_s_wready (output, 1): the W handshake.
REQ-008 SHALL have port o_axi_s_b, output, axi_b_t: write response (id, resp).
REQ-009 SHALL have ports o_axi_s_bvalid (output, 1) and i_axi_s_bready (input, 1): the B handshake.
REQ-010 SHALL have port i_axi_s_ar, input, axi_ar_t: read address.
REQ-011 SHALL have ports i_axi_s_arvalid (input, 1) and o_axi_s_arready (output, 1): the AR handshake.
REQ-012 SHALL have port o_axi_s_r, output, axi_r_t: read data (id, data, resp, last).
REQ-013 SHALL have ports o_axi_s_rvalid (output, 1) and i_axi_s_rready (input, 1): the R handshake.

Function
REQ-014 SHALL accept only single-beat INCR transactions of 8 bytes; len, size and burst are ignored, and last is always 1 on R.
REQ-015 SHALL use word index = addr[3 +: IDX_W]; addr[2:0] is ignored.
REQ-016 SHALL hold one AW slot and one W slot, filled independently: awready = AW slot empty; wready = W slot empty; handshake = valid && ready in the same cycle.
REQ-017 SHALL commit a write in the first cycle in which both slots are full and bvalid is 0: the byte lanes with strb=1 are updated, the other lanes are unchanged.
REQ-018 In the commit cycle, SHALL set bvalid=1 at the next edge with b.id = AW id and b.resp = OKAY (0), and clear both slots.
REQ-019 SHALL keep bvalid and b stable until bready=1; bvalid clears at the edge where bvalid && bready.
REQ-020 SHALL allow the AW slot to fill before the W slot and vice versa; an arbitrary gap between AW and W is legal.
REQ-021 Minimum write latency: B valid 2 cycles after AW and W handshake together.
REQ-022 SHALL drive arready = !rvalid, giving one outstanding read.
REQ-023 On the AR handshake, SHALL set rvalid=1 at the next edge, with r.data = memory word before any same-cycle write commit, r.id = AR id, r.resp = OKAY, r.last = 1.
REQ-024 SHALL keep rvalid and r stable until rready=1; rvalid clears at the edge where rvalid && rready.
REQ-025 SHALL keep the read and write paths independent; a same-cycle AR handshake and write commit to the same index returns the old data.
REQ-026 A memory word never written SHALL read as all-X (logic storage, never initialised).

Reset
REQ-027 While rst=1, SHALL hold awready=0, wready=0, bvalid=0, arready=0, rvalid=0, with b and r all-zero.
REQ-028 At the first edge after rst falls, SHALL set awready=1, wready=1, arready=1.
REQ-029 Reset asserted mid-transaction SHALL discard slot contents, pending B and pending R.
REQ-030 Reset SHALL NOT clear memory contents, and no write SHALL be committed while rst=1.

Configuration
REQ-031 With macro AXI_MEM_SUB_DECERR_EN defined, SHALL flag any transaction with addr[AXI_ADDR_WIDTH-1 : 3+IDX_W] nonzero as out of range.
REQ-032 With AXI_MEM_SUB_DECERR_EN defined, an out-of-range write SHALL not modify memory and SHALL return resp = DECERR (3).
REQ-033 With AXI_MEM_SUB_DECERR_EN defined, an out-of-range read SHALL return data = 0 and resp = DECERR (3).
REQ-034 Without AXI_MEM_SUB_DECERR_EN, upper address bits SHALL be ignored (aliasing), resp SHALL always be OKAY, and no decode logic SHALL be present.

Verification
REQ-035 Write addr 0x40, data 0x1122334455667788, strb 0xFF, AW and W in the same cycle, bready=1 -> bvalid 2 cycles later, resp 0; a read of 0x40 then returns 0x1122334455667788.
REQ-036 Send W (data 0xAA.., strb 0x0F) 5 cycles before AW to 0x40 (prior data as above) -> wready=0 until commit; the read returns 0x11223344AAAAAAAA.
REQ-037 Hold bready=0 for 4 cycles after bvalid, then issue a second AW/W -> both slots fill but no commit until B is accepted; b stable throughout.
REQ-038 Read with rready held low for 3 cycles -> arready=0 and r.data stable until the R handshake; r.id equals AR id 5.
REQ-039 Assert rst while AW is captured but W is pending -> all valids 0; after reset, a read of that address returns its prior contents.
REQ-040 With AXI_MEM_SUB_DECERR_EN and DEPTH=4096, write/read of addr 0x10000 -> resp 3, read data 0, memory unchanged; without the macro -> aliases to index 0, resp 0.
